regfile_sb: RTL
===============

Name: regfile_sb

Overview:
Parametrised successor to the core's single-write, two-read register file. Adds N read ports, a second write port for load writeback, write-to-read bypass, a hardwired zero register, and a per-register pending-write scoreboard. Sits in the decode/writeback boundary of the RISC-V pipeline. Issue logic uses it to detect RAW hazards on outstanding loads.

Parameters:
XLEN, 32, data width of each register.
NREGS, 32, number of architectural registers. Must be a power of two, at least 2.
NRD, 2, number of read ports.
BYPASS, 1, 1 = same-cycle write data is forwarded to read ports; 0 = reads return the stored value only.
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and scoreboard sets.
AW (localparam), $clog2(NREGS), address width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
w_en  in  1  ALU writeback enable (write port 0).
w_addr  in  AW  port 0 address.
w_data  in  XLEN  port 0 data.
l_en  in  1  load writeback enable (write port 1); also clears that register's busy bit.
l_addr  in  AW  port 1 address.
l_data  in  XLEN  port 1 data.
sb_set  in  1  load issued; marks sb_addr pending.
sb_addr  in  AW  register to mark pending.
rd_addr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
rd_data  out  NRD*XLEN  packed read data, combinational.
rd_busy  out  NRD  per-port: addressed register has a pending load, combinational.
busy_vec  out  NREGS  registered scoreboard state.
wr_collide  out  1  registered one-cycle pulse: both write ports targeted the same address.

Behaviour:
- Reset (async, active-high):
  - All registers are 0, busy_vec is 0, wr_collide is 0.
  - Reset asserted mid-operation discards any writes or sets in that cycle.
  - Deassertion is synchronised externally.
- Writes: take effect on the rising clk edge. Latency is 1 cycle to the stored value.
- Port collision (w_en & l_en & w_addr==l_addr):
  - Port 0 data is stored; port 1 data is dropped.
  - wr_collide=1 in the following cycle.
  - The busy bit is still cleared by l_en.
- Different addresses: both writes occur in the same cycle.
- ZERO_REG=1:
  - Writes to address 0 are ignored.
  - rd_data for address 0 is always 0.
  - sb_set to address 0 is ignored.
  - rd_busy for address 0 is always 0.
  - Collisions at address 0 do not pulse wr_collide.
- Read, per port k:
  - If ZERO_REG and addr==0: data is 0.
  - Else if BYPASS and w_en and w_addr==addr: data is w_data.
  - Else if BYPASS and l_en and l_addr==addr: data is l_data.
  - Else: data is the stored register value.
- Scoreboard, next busy[i] per register:
  - If sb_set and sb_addr==i: busy[i] becomes 1. Set wins over a simultaneous l_en clear at the same address.
  - Else if l_en and l_addr==i: busy[i] becomes 0.
  - Else: busy[i] holds.
- w_en does not touch busy.
- rd_busy[k] = busy[addr_k] & ~(BYPASS & l_en & l_addr==addr_k). This lets a consumer proceed in the load's writeback cycle.
- sb_set on an already-busy register leaves it busy. No counting; this is a single outstanding load per register.
- Out-of-range addresses cannot occur (NREGS is a power of two).

Decomposition:
- Shared package regfile_pkg:
  - XLEN and NREGS defaults.
  - Function clog2 helper.
  - Typedef reg_addr_t [AW-1:0] and xlen_t [XLEN-1:0].
- Sub-module regfile_rport: one read port with the bypass/zero mux. It is instantiated NRD times in a generate loop.
- Storage, scoreboard and the collision register live in the top module.

Test Plan:
- Reset with async assertion mid-clock, then release. Write 1..31 to regs 1..31 via port 0, one per cycle. Read all addresses on both ports -> each reg i reads i. Reg 0 reads 0, including after a port 0 write of 0xDEADBEEF to address 0.
- Same-cycle bypass: w_en to reg 5 with 0x1234 while rd_addr[0]=5 -> rd_data[0]=0x1234 in that cycle. With BYPASS=0 -> the old value is returned until the next cycle.
- Collision: w (reg 7, 0xAAAA) and l (reg 7, 0x5555) in the same cycle -> reg 7 = 0xAAAA and wr_collide=1 for exactly one cycle. Repeat at reg 0 -> wr_collide stays 0.
- Scoreboard: sb_set reg 9 -> busy_vec[9]=1 next cycle and rd_busy=1 on any port reading 9. l_en reg 9 with 0x99 -> rd_busy=0 and rd_data=0x99 in that cycle; busy_vec[9]=0 after the edge.
- Set/clear race: sb_set reg 3 and l_en reg 3 in the same cycle -> busy_vec[3]=1 and reg 3 holds l_data. Then assert reset with busy bits set -> busy_vec=0 immediately, without waiting for clk.
- NRD=4, XLEN=64, NREGS=16 instance: write 64-bit patterns and read 4 different addresses simultaneously -> all four ports return correct values.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default sizes,
// address-width helper and common data types.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   localparam int AW_DEF = clog2(NREGS_DEF);

   typedef logic [AW_DEF-1:0]   reg_addr_t;
   typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_rport.sv
// One read port: zero-register override, then same-cycle forwarding from the
// ALU port, then from the load port, else the stored value.
module regfile_rport
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int AW       = AW_DEF,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic [AW-1:0]   i_addr,
   input  logic [XLEN-1:0] i_stored,
   input  logic            i_busy,
   input  logic            i_w_en,
   input  logic [AW-1:0]   i_w_addr,
   input  logic [XLEN-1:0] i_w_data,
   input  logic            i_l_en,
   input  logic [AW-1:0]   i_l_addr,
   input  logic [XLEN-1:0] i_l_data,
   output logic [XLEN-1:0] o_data,
   output logic            o_busy
);

   logic w_zero;
   logic w_hit_w;
   logic w_hit_l;

   assign w_zero  = (ZERO_REG != 0) && (i_addr == '0);
   assign w_hit_w = (BYPASS != 0) && i_w_en && (i_w_addr == i_addr);
   assign w_hit_l = (BYPASS != 0) && i_l_en && (i_l_addr == i_addr);

   always_comb begin
      o_data = i_stored;
      if (w_zero)       o_data = '0;
      else if (w_hit_w) o_data = i_w_data;
      else if (w_hit_l) o_data = i_l_data;
      // A load landing this cycle is visible through the bypass, so the
      // consumer need not stall on it.
      o_busy = i_busy & ~w_hit_l & ~w_zero;
   end

endmodule

// File: rtl/regfile_sb.sv
// Register file with two write ports (ALU, load), NRD bypassed read ports and
// a per-register pending-load scoreboard for RAW hazard detection.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                w_en,
   input  logic [AW-1:0]       w_addr,
   input  logic [XLEN-1:0]     w_data,
   input  logic                l_en,
   input  logic [AW-1:0]       l_addr,
   input  logic [XLEN-1:0]     l_data,
   input  logic                sb_set,
   input  logic [AW-1:0]       sb_addr,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   output logic [NREGS-1:0]    busy_vec,
   output logic                wr_collide
);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [NREGS-1:0] r_busy;
   logic             r_collide;

   logic [NREGS-1:0] w_wr0;
   logic [NREGS-1:0] w_wr1;
   logic [NREGS-1:0] w_busy_nxt;
   logic             w_collide;

   always_comb begin
      w_wr0      = '0;
      w_wr1      = '0;
      w_busy_nxt = r_busy;
      for (int i = 0; i < NREGS; i++) begin
         if (!((ZERO_REG != 0) && (i == 0))) begin
            w_wr0[i] = w_en && (w_addr == AW'(i));
            w_wr1[i] = l_en && (l_addr == AW'(i));
            // A new load issue outranks the completion of the previous one.
            if (sb_set && (sb_addr == AW'(i)))    w_busy_nxt[i] = 1'b1;
            else if (l_en && (l_addr == AW'(i))) w_busy_nxt[i] = 1'b0;
         end
      end
   end

   assign w_collide = w_en && l_en && (w_addr == l_addr) &&
                      !((ZERO_REG != 0) && (w_addr == '0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         r_busy    <= '0;
         r_collide <= 1'b0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (w_wr0[i])      r_regs[i] <= w_data;
            else if (w_wr1[i]) r_regs[i] <= l_data;
         end
         r_busy    <= w_busy_nxt;
         r_collide <= w_collide;
      end
   end

   assign busy_vec   = r_busy;
   assign wr_collide = r_collide;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] w_ra;
      assign w_ra = rd_addr[k*AW +: AW];

      regfile_rport #(
         .XLEN     (XLEN),
         .AW       (AW),
         .BYPASS   (BYPASS),
         .ZERO_REG (ZERO_REG)
      ) u_rport (
         .i_addr   (w_ra),
         .i_stored (r_regs[w_ra]),
         .i_busy   (r_busy[w_ra]),
         .i_w_en   (w_en),
         .i_w_addr (w_addr),
         .i_w_data (w_data),
         .i_l_en   (l_en),
         .i_l_addr (l_addr),
         .i_l_data (l_data),
         .o_data   (rd_data[k*XLEN +: XLEN]),
         .o_busy   (rd_busy[k])
      );
   end

endmodule
